// File: rtl/joybus_pkg.sv
// Shared Joybus constants, command codes and FSM state encoding.
// Imported by the controller-side device and by JOYBUS_host.
package joybus_pkg;

  localparam logic [7:0]  CMD_INFO  = 8'h00;
  localparam logic [7:0]  CMD_POLL  = 8'h01;
  localparam logic [7:0]  CMD_RESET = 8'hFF;
  localparam logic [23:0] INFO_RSP  = 24'h050002;

  localparam int unsigned BIT_US   = 4;
  localparam int unsigned SHORT_US = 1;
  localparam int unsigned LONG_US  = 3;
  localparam int unsigned DSTOP_US = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_BIT,
    S_RX_STOP,
    S_GAP,
    S_TX_BIT,
    S_TX_STOP,
    S_IGNORE
  } state_t;

endpackage

// File: rtl/joybus_bit_tx.sv
// Drives one Joybus data bit or the device stop bit as a low/high pattern.
// bit_done_c is high in the final cycle so the next bit can start with no gap.
module joybus_bit_tx
  import joybus_pkg::*;
#(
  parameter int unsigned CYC_PER_US = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bit_val,
  input  logic stop,
  output logic drv_low,
  output logic bit_done_c
);

  localparam int unsigned CYC_W = 16;

  logic             active;
  logic [CYC_W-1:0] cyc;
  logic [2:0]       us;
  logic [2:0]       low_us;
  logic [2:0]       tot_us;
  logic             us_tick_c;

  assign us_tick_c  = active && (cyc == CYC_W'(CYC_PER_US - 1));
  assign bit_done_c = us_tick_c && ((us + 3'd1) == tot_us);

  // Microsecond prescaler; release at low_us, finish at tot_us.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= 1'b0;
      cyc     <= '0;
      us      <= '0;
      low_us  <= '0;
      tot_us  <= '0;
      drv_low <= 1'b0;
    end else if (start) begin
      active  <= 1'b1;
      cyc     <= '0;
      us      <= '0;
      low_us  <= stop ? 3'(DSTOP_US) : (bit_val ? 3'(SHORT_US) : 3'(LONG_US));
      tot_us  <= stop ? 3'(DSTOP_US) : 3'(BIT_US);
      drv_low <= 1'b1;
    end else if (active) begin
      if (us_tick_c) begin
        cyc <= '0;
        us  <= us + 3'd1;
        if ((us + 3'd1) == low_us) drv_low <= 1'b0;
        if (bit_done_c) active <= 1'b0;
      end else begin
        cyc <= cyc + CYC_W'(1);
      end
    end
  end

endmodule

// File: rtl/joybus_device.sv
// N64 controller emulation on the open-drain Joybus line: decodes the console
// command byte and answers INFO/RESET with the identity or POLL with cntlr_data.
module joybus_device
  import joybus_pkg::*;
#(
  parameter int unsigned CYC_PER_US = 50,
  parameter int unsigned GAP_US     = 2,
  parameter int unsigned IDLE_US    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  inout  wire         JB,
  input  logic [31:0] cntlr_data,
  output logic [7:0]  cmd_byte,
  output logic        cmd_vld,
  output logic        busy,
  output logic        rsp_done,
  output logic        err
);

  localparam int unsigned TW         = 16;
  localparam int unsigned SAMPLE_CYC = 2 * CYC_PER_US;
  localparam int unsigned IDLE_CYC   = IDLE_US * CYC_PER_US;
  localparam int unsigned GAP_CYC    = GAP_US * CYC_PER_US;
  localparam int unsigned DSTOP_CYC  = DSTOP_US * CYC_PER_US;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [5:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    rx_sh, rx_sh_n;
  logic [31:0]   tx_sh, tx_sh_n;
  logic [2:0]    tx_len, tx_len_n;
  logic          in_stop, in_stop_n;
  logic [7:0]    cmd_byte_n;
  logic          cmd_vld_n, err_n, rsp_done_n;
  logic [1:0]    sync_q;
  logic          line, line_prev, fall, rise;
  logic          tx_start_c, tx_bit_c, tx_stop_c;
  logic          drv_low, bit_done_c;
  logic [31:0]   src_c;

  assign JB    = drv_low ? 1'b0 : 1'bz;
  assign line  = sync_q[1];
  assign fall  = line_prev & ~line;
  assign rise  = ~line_prev & line;
  assign src_c = (tx_len == 3'd4) ? cntlr_data : {INFO_RSP, 8'h00};

  joybus_bit_tx #(.CYC_PER_US(CYC_PER_US)) u_bit_tx (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (tx_start_c),
    .bit_val    (tx_bit_c),
    .stop       (tx_stop_c),
    .drv_low    (drv_low),
    .bit_done_c (bit_done_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      timer     <= '0;
      bit_cnt   <= '0;
      rx_sh     <= '0;
      tx_sh     <= '0;
      tx_len    <= '0;
      in_stop   <= 1'b0;
      cmd_byte  <= '0;
      cmd_vld   <= 1'b0;
      err       <= 1'b0;
      rsp_done  <= 1'b0;
      busy      <= 1'b0;
      sync_q    <= 2'b11;
      line_prev <= 1'b1;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      bit_cnt   <= bit_cnt_n;
      rx_sh     <= rx_sh_n;
      tx_sh     <= tx_sh_n;
      tx_len    <= tx_len_n;
      in_stop   <= in_stop_n;
      cmd_byte  <= cmd_byte_n;
      cmd_vld   <= cmd_vld_n;
      err       <= err_n;
      rsp_done  <= rsp_done_n;
      busy      <= (state_n != S_IDLE);
      sync_q    <= {sync_q[0], JB};
      line_prev <= line;
    end
  end

  always_comb begin
    state_n    = state;
    timer_n    = timer + TW'(1);
    bit_cnt_n  = bit_cnt;
    rx_sh_n    = rx_sh;
    tx_sh_n    = tx_sh;
    tx_len_n   = tx_len;
    in_stop_n  = in_stop;
    cmd_byte_n = cmd_byte;
    cmd_vld_n  = 1'b0;
    err_n      = 1'b0;
    rsp_done_n = 1'b0;
    tx_start_c = 1'b0;
    tx_bit_c   = tx_sh[31];
    tx_stop_c  = 1'b0;
    unique case (state)
      S_IDLE: begin
        timer_n   = '0;
        in_stop_n = 1'b0;
        if (fall) begin
          state_n   = S_RX_BIT;
          bit_cnt_n = '0;
        end
      end
      S_RX_BIT: begin
        // timer measures time since the latest falling edge
        if (fall) begin
          timer_n = '0;
        end else if (timer == TW'(SAMPLE_CYC - 1)) begin
          rx_sh_n = {rx_sh[6:0], line};
          if (bit_cnt == 6'd7) state_n = S_RX_STOP;
          else bit_cnt_n = bit_cnt + 6'd1;
        end else if (timer == TW'(IDLE_CYC - 1)) begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_RX_STOP: begin
        if (!in_stop) begin
          if (fall) begin
            in_stop_n = 1'b1;
            timer_n   = '0;
          end else if (timer == TW'(IDLE_CYC - 1)) begin
            err_n   = 1'b1;
            state_n = S_IDLE;
          end
        end else if (rise) begin
          cmd_byte_n = rx_sh;
          cmd_vld_n  = 1'b1;
          timer_n    = '0;
          if (rx_sh == CMD_INFO || rx_sh == CMD_RESET) begin
            tx_len_n = 3'd3;
            state_n  = S_GAP;
          end else if (rx_sh == CMD_POLL) begin
            tx_len_n = 3'd4;
            state_n  = S_GAP;
          end else begin
            state_n = S_IGNORE;
          end
        end else if (timer == TW'(DSTOP_CYC - 1)) begin
          err_n   = 1'b1;
          timer_n = '0;
          state_n = S_IGNORE;
        end
      end
      S_GAP: begin
        if (fall) begin
          err_n   = 1'b1;
          timer_n = '0;
          state_n = S_IGNORE;
        end else if (timer == TW'(GAP_CYC - 1)) begin
          tx_start_c = 1'b1;
          tx_bit_c   = src_c[31];
          tx_sh_n    = {src_c[30:0], 1'b0};
          bit_cnt_n  = '0;
          state_n    = S_TX_BIT;
        end
      end
      S_TX_BIT: begin
        if (bit_done_c) begin
          tx_start_c = 1'b1;
          if (bit_cnt == ({tx_len, 3'b000} - 6'd1)) begin
            tx_stop_c = 1'b1;
            state_n   = S_TX_STOP;
          end else begin
            tx_sh_n   = {tx_sh[30:0], 1'b0};
            bit_cnt_n = bit_cnt + 6'd1;
          end
        end
      end
      S_TX_STOP: begin
        if (bit_done_c) begin
          rsp_done_n = 1'b1;
          state_n    = S_IDLE;
        end
      end
      S_IGNORE: begin
        if (!line) timer_n = '0;
        else if (timer == TW'(IDLE_CYC - 1)) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_joybus_device.sv
// Bench for joybus_device: host-side bit driver, response decoder and
// event counters, with a command vector table plus error and reset sequences.
module tb_joybus_device;

  localparam int unsigned CYC = 4;

  logic        clk;
  logic        rst_n;
  logic        host_low;
  logic [31:0] cntlr_data;
  logic [7:0]  cmd_byte;
  logic        cmd_vld, busy, rsp_done, err;
  wire         jb;

  pullup (jb);
  assign jb = host_low ? 1'b0 : 1'bz;

  joybus_device #(.CYC_PER_US(CYC), .GAP_US(2), .IDLE_US(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .JB         (jb),
    .cntlr_data (cntlr_data),
    .cmd_byte   (cmd_byte),
    .cmd_vld    (cmd_vld),
    .busy       (busy),
    .rsp_done   (rsp_done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int vld_cnt = 0, err_cnt = 0, done_cnt = 0, dev_low_cnt = 0, both_cnt = 0;

  always @(negedge clk) begin
    if (cmd_vld) vld_cnt++;
    if (err) err_cnt++;
    if (rsp_done) done_cnt++;
    if (cmd_vld && err) both_cnt++;
    if (!host_low && jb === 1'b0) dev_low_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Host drive tasks are entered and left on a falling clock edge.
  task automatic host_bit(input logic b);
    host_low = 1'b1;
    repeat (b ? CYC : 3 * CYC) @(negedge clk);
    host_low = 1'b0;
    repeat (b ? 3 * CYC : CYC) @(negedge clk);
  endtask

  task automatic host_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) host_bit(b[i]);
  endtask

  task automatic host_stop();
    host_low = 1'b1;
    repeat (CYC) @(negedge clk);
    host_low = 1'b0;
  endtask

  // Decodes device bits by low time: under 2 us is a '1'.
  task automatic rx_resp(input int nbits, input bit clr, output logic [31:0] val,
                         output int gap, output int stop_len, output int tmo);
    int w, l;
    val = '0; gap = 0; stop_len = 0; tmo = 0;
    for (int i = 0; i <= nbits; i++) begin
      w = 0;
      do begin @(negedge clk); w++; end while (jb !== 1'b0 && w < 200);
      if (w >= 200) tmo++;
      if (i == 0) gap = w;
      l = 0;
      do begin @(negedge clk); l++; end while (jb === 1'b0 && l < 40);
      if (i < nbits) val = {val[30:0], (l < 2 * CYC)};
      else stop_len = l;
      if (i == 0 && clr) cntlr_data = 32'h0;
    end
  endtask

  typedef struct {
    logic [7:0]  cmd;
    int          n_extra;
    logic [15:0] extra;
    logic [31:0] data;
    int          rsp_bytes;
    logic [31:0] rsp;
    bit          clr;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    int v0, e0, d0, l0, gap, slen, tmo;
    logic [31:0] val;
    v0 = vld_cnt; e0 = err_cnt; d0 = done_cnt; l0 = dev_low_cnt;
    cntlr_data = v.data;
    @(negedge clk);
    host_byte(v.cmd);
    for (int k = 0; k < v.n_extra; k++) host_byte(k == 0 ? v.extra[15:8] : v.extra[7:0]);
    host_stop();
    if (v.rsp_bytes > 0) begin
      rx_resp(v.rsp_bytes * 8, v.clr, val, gap, slen, tmo);
      check({tag, "_rsp"}, val, v.rsp);
      check({tag, "_timeout"}, 32'(tmo), 32'd0);
      check({tag, "_gap_2us"}, 32'(gap >= 2 * CYC + 1 && gap <= 2 * CYC + 5), 32'd1);
      check({tag, "_stop_2us"}, 32'(slen), 32'(2 * CYC));
    end
    repeat (12 * CYC) @(negedge clk);
    check({tag, "_cmd_byte"}, 32'(cmd_byte), 32'(v.cmd));
    check({tag, "_vld_pulses"}, 32'(vld_cnt - v0), 32'd1);
    check({tag, "_err_pulses"}, 32'(err_cnt - e0), 32'd0);
    check({tag, "_done_pulses"}, 32'(done_cnt - d0), (v.rsp_bytes > 0) ? 32'd1 : 32'd0);
    check({tag, "_dev_drove"}, 32'(dev_low_cnt != l0), (v.rsp_bytes > 0) ? 32'd1 : 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  vec_t vecs[5];

  initial begin
    int e0, v0, w;
    vecs[0] = '{cmd: 8'h00, n_extra: 0, extra: 16'h0,    data: 32'h0,         rsp_bytes: 3, rsp: 32'h0005_0002, clr: 1'b0};
    vecs[1] = '{cmd: 8'h01, n_extra: 0, extra: 16'h0,    data: 32'h8000_7F81, rsp_bytes: 4, rsp: 32'h8000_7F81, clr: 1'b1};
    vecs[2] = '{cmd: 8'hFF, n_extra: 0, extra: 16'h0,    data: 32'hDEAD_BEEF, rsp_bytes: 3, rsp: 32'h0005_0002, clr: 1'b0};
    vecs[3] = '{cmd: 8'h02, n_extra: 2, extra: 16'hC01B, data: 32'h1234_5678, rsp_bytes: 0, rsp: 32'h0,         clr: 1'b0};
    vecs[4] = '{cmd: 8'h01, n_extra: 0, extra: 16'h0,    data: 32'h1234_5678, rsp_bytes: 4, rsp: 32'h1234_5678, clr: 1'b0};

    rst_n = 1'b0; host_low = 1'b0; cntlr_data = '0;
    #23;
    check("reset_outputs", {cmd_byte, cmd_vld, busy, rsp_done, err}, 32'h0);
    check("reset_jb_released", 32'(jb), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Truncated frame: five bits then a long high line.
    e0 = err_cnt; v0 = vld_cnt;
    @(negedge clk);
    host_bit(1'b1); host_bit(1'b0); host_bit(1'b1); host_bit(1'b1); host_bit(1'b0);
    repeat (10 * CYC) @(negedge clk);
    check("trunc_err_pulses", 32'(err_cnt - e0), 32'd1);
    check("trunc_no_vld", 32'(vld_cnt - v0), 32'd0);
    check("trunc_busy", 32'(busy), 32'd0);
    check("trunc_jb_released", 32'(jb), 32'd1);

    // Reset while the device is pulling the line low.
    cntlr_data = 32'hA5C3_0F1E;
    @(negedge clk);
    host_byte(8'h01);
    host_stop();
    w = 0;
    do begin @(negedge clk); w++; end while (jb !== 1'b0 && w < 200);
    check("rst_mid_tx_reached", 32'(w < 200), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_tx_jb", 32'(jb), 32'd1);
    check("rst_mid_tx_outputs", {cmd_byte, cmd_vld, busy, rsp_done, err}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    run_vec(vecs[4], "after_rst");

    check("vld_err_overlap", 32'(both_cnt), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
